// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares one register-file write port between the pipeline
// and a FIFO of long-latency results, with starvation forcing and hazard detection.
package wb_port_arbiter_pkg;
    typedef logic [31:0] word;
    typedef enum logic [1:0] {
        REG_NOP        = 2'd0,
        WRITE_REG_DATA = 2'd1,
        READ_REG_DATA  = 2'd2
    } reg_file_op_t;
endpackage

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  reg_file_op_t                  pipe_reg_op,
    input  logic [4:0]                    pipe_rd,
    input  word                           pipe_data,
    output logic                          pipe_stall,
    input  logic                          lu_valid,
    input  logic [4:0]                    lu_rd,
    input  word                           lu_data,
    output logic                          lu_ready,
    input  logic [4:0]                    rs1_addr,
    input  logic [4:0]                    rs2_addr,
    output logic                          hazard,
    output logic                          rf_we,
    output logic [4:0]                    rf_rd,
    output word                           rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       buf_rd   [FIFO_DEPTH];
    word              buf_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve;

    logic pipe_grant, pop, push;

    assign fifo_count = count;
    assign lu_ready   = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign pipe_stall = !rst && (starve == STV_W'(STARVE_LIMIT));

    assign pipe_grant = !rst && (pipe_reg_op == WRITE_REG_DATA) && (pipe_rd != 5'd0) && !pipe_stall;
    assign pop        = !rst && !pipe_grant && (count != '0);
    // A zero-destination result is acknowledged but never occupies a slot.
    assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);

    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = 5'd0;
        rf_data = '0;
        if (pipe_grant) begin
            rf_we   = 1'b1;
            rf_rd   = pipe_rd;
            rf_data = pipe_data;
        end else if (pop) begin
            rf_we   = 1'b1;
            rf_rd   = buf_rd[rd_ptr];
            rf_data = buf_data[rd_ptr];
        end
    end

    // Slot i is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] off;
        hazard = 1'b0;
        off    = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if (!rst && ({1'b0, off} < count) &&
                ((rs1_addr != 5'd0 && buf_rd[i] == rs1_addr) ||
                 (rs2_addr != 5'd0 && buf_rd[i] == rs2_addr)))
                hazard = 1'b1;
        end
    end

    // NOTE: buffer storage has no reset; occupancy tracking alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd[wr_ptr]   <= lu_rd;
            buf_data[wr_ptr] <= lu_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop || count == '0)
                starve <= '0;
            else if (starve != STV_W'(STARVE_LIMIT))
                starve <= starve + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a queue-based
// model of the write-back arbitration rules.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic         clk = 1'b0;
    logic         rst;
    reg_file_op_t pipe_reg_op;
    logic [4:0]   pipe_rd, lu_rd, rs1_addr, rs2_addr, rf_rd;
    word          pipe_data, lu_data, rf_data;
    logic         lu_valid, pipe_stall, lu_ready, hazard, rf_we;
    logic [2:0]   fifo_count;

    int total = 0;
    int bad   = 0;

    int         q_rd[$];
    logic [31:0] q_data[$];
    int         m_starve = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_reg_op(pipe_reg_op), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input reg_file_op_t op, input int prd, input logic [31:0] pd,
                         input logic lv, input int lrd, input logic [31:0] ld, input int r1, input int r2);
        rst = r; pipe_reg_op = op; pipe_rd = 5'(prd); pipe_data = pd;
        lu_valid = lv; lu_rd = 5'(lrd); lu_data = ld; rs1_addr = 5'(r1); rs2_addr = 5'(r2);
    endtask

    // Check all outputs against the model, clock once, then advance the model.
    task automatic tick();
        int n;
        bit e_ready, e_stall, pw, hw, e_haz;
        int e_rd;
        logic [31:0] e_data;
        #1;
        n       = q_rd.size();
        e_ready = !rst && n < DEPTH;
        e_stall = !rst && m_starve == LIMIT;
        pw      = !rst && pipe_reg_op == WRITE_REG_DATA && pipe_rd != 0 && !e_stall;
        hw      = !rst && !pw && n > 0;
        e_rd    = pw ? int'(pipe_rd) : hw ? q_rd[0] : 0;
        e_data  = pw ? pipe_data : hw ? q_data[0] : 32'h0;
        e_haz   = 1'b0;
        if (!rst)
            foreach (q_rd[i])
                if ((rs1_addr != 0 && q_rd[i] == int'(rs1_addr)) || (rs2_addr != 0 && q_rd[i] == int'(rs2_addr)))
                    e_haz = 1'b1;
        chk("lu_ready", 32'(lu_ready), 32'(e_ready));
        chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
        chk("rf_we", 32'(rf_we), 32'(pw || hw));
        chk("rf_rd", 32'(rf_rd), 32'(e_rd));
        chk("rf_data", rf_data, e_data);
        chk("hazard", 32'(hazard), 32'(e_haz));
        @(posedge clk);
        if (rst) begin
            q_rd.delete(); q_data.delete(); m_starve = 0;
        end else begin
            if (hw) begin
                void'(q_rd.pop_front()); void'(q_data.pop_front());
            end
            if (lu_valid && e_ready && lu_rd != 0) begin
                q_rd.push_back(int'(lu_rd)); q_data.push_back(lu_data);
            end
            if (hw || n == 0) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
        end
        #1;
        chk("fifo_count", 32'(fifo_count), 32'(q_rd.size()));
    endtask

    initial begin
        drive(1, REG_NOP, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        tick();
        chk("reset_count", 32'(fifo_count), 32'd0);

        // Single long-latency result with pipeline idle.
        drive(0, REG_NOP, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        #1 chk("r19_no_bypass", 32'(rf_we), 32'd0);
        tick();
        drive(0, REG_NOP, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r19_we", 32'(rf_we), 32'd1);
        chk("r19_rd", 32'(rf_rd), 32'd5);
        chk("r19_data", rf_data, 32'hDEAD_BEEF);
        tick();
        chk("r19_empty", 32'(fifo_count), 32'd0);

        // Starvation: one buffered entry behind continuous pipeline writes.
        drive(0, WRITE_REG_DATA, 1, 32'h100, 1, 3, 32'h3333, 0, 0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            drive(0, WRITE_REG_DATA, k + 1, 32'h100 + 32'(k), 0, 0, 0, 0, 0);
            #1;
            chk("r20_stall", 32'(pipe_stall), 32'(k == 9));
            if (k == 9) chk("r20_forced_rd", 32'(rf_rd), 32'd3);
            tick();
        end

        // Fill the buffer while the pipeline keeps the port.
        for (int k = 0; k < 5; k++) begin
            drive(0, WRITE_REG_DATA, 20 + k, 32'h200, 1, 10 + k, 32'hA000 + 32'(k), 0, 0);
            #1 if (k == 4) chk("r21_full_ready", 32'(lu_ready), 32'd0);
            tick();
        end
        chk("r21_full_count", 32'(fifo_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            drive(0, REG_NOP, 0, 0, 0, 0, 0, 0, 0);
            #1 chk("r21_drain_order", 32'(rf_rd), 32'(10 + k));
            tick();
        end

        // Hazard on a buffered destination; rd=0 results never buffer.
        drive(0, WRITE_REG_DATA, 1, 32'h1, 1, 7, 32'h7777, 0, 0);
        tick();
        drive(0, WRITE_REG_DATA, 2, 32'h2, 0, 0, 0, 7, 0);
        #1 chk("r22_hazard", 32'(hazard), 32'd1);
        tick();
        drive(0, REG_NOP, 0, 0, 0, 0, 0, 0, 7);
        tick();
        drive(0, REG_NOP, 0, 0, 1, 0, 32'h5555, 0, 0);
        tick();
        drive(0, REG_NOP, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r22_zero_hazard", 32'(hazard), 32'd0);
        chk("r22_zero_count", 32'(fifo_count), 32'd0);
        tick();

        // Pipeline request to x0 yields the port to the buffer head.
        drive(0, REG_NOP, 0, 0, 1, 9, 32'h9999, 0, 0);
        tick();
        drive(0, WRITE_REG_DATA, 0, 32'hFFFF, 0, 0, 0, 0, 0);
        #1;
        chk("r23_we", 32'(rf_we), 32'd1);
        chk("r23_rd", 32'(rf_rd), 32'd9);
        tick();

        // Reset with three buffered entries.
        for (int k = 0; k < 3; k++) begin
            drive(0, WRITE_REG_DATA, 4, 32'h4, 1, 15 + k, 32'hB000 + 32'(k), 0, 0);
            tick();
        end
        drive(1, REG_NOP, 0, 0, 1, 6, 32'h6, 15, 16);
        #1 chk("r24_we_in_rst", 32'(rf_we), 32'd0);
        tick();
        chk("r24_count", 32'(fifo_count), 32'd0);
        drive(0, REG_NOP, 0, 0, 0, 0, 0, 15, 16);
        #1 chk("r24_ready", 32'(lu_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            #1 chk("r24_no_write", 32'(rf_we), 32'd0);
            tick();
        end

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 59) == 0),
                  reg_file_op_t'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                  $urandom,
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)),
                  $urandom,
                  int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 12)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of entries in the long-latency result buffer (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set the consecutive no-pop cycles after which the buffer head is forced onto the port.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- pipe_reg_op  in  reg_file_op_t  write-back request; WRITE_REG_DATA = write
- pipe_rd  in  5  destination register of pipeline write
- pipe_data  in  word  pipeline write data
- pipe_stall  out  1  pipeline write not accepted this cycle; upstream holds its request
- lu_valid  in  1  long-latency unit result valid
- lu_rd  in  5  destination of long-latency result
- lu_data  in  word  long-latency result data
- lu_ready  out  1  buffer can accept a result this cycle
- rs1_addr, rs2_addr  in  5 each  decode-stage source registers
- hazard  out  1  a buffered result targets rs1_addr or rs2_addr
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_data  out  word  register-file write data
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries

Function
REQ-004 A long-latency result SHALL be accepted when lu_valid && lu_ready; an accepted result with lu_rd != 0 SHALL be pushed at the buffer tail, one with lu_rd == 0 SHALL be discarded.
REQ-005 lu_ready SHALL equal (fifo_count < FIFO_DEPTH) from registered state; it SHALL NOT depend on same-cycle pops.
REQ-006 Accepted results SHALL never bypass the buffer: the earliest register-file write of a result is the cycle after acceptance.
REQ-007 Each cycle the port SHALL be granted in priority: (a) pipeline, if pipe_reg_op == WRITE_REG_DATA, pipe_rd != 0 and pipe_stall == 0; (b) otherwise buffer head, if fifo_count > 0; (c) otherwise none.
REQ-008 A pipeline request with pipe_rd == 0 SHALL be accepted without a write and SHALL leave the port free for the buffer head.
REQ-009 On grant, rf_we = 1 with rf_rd/rf_data taken from the winner combinationally; with no grant, rf_we = 0, rf_rd = 0, rf_data = 0.
REQ-010 A buffer-head grant SHALL pop the head in that cycle; results SHALL reach the register file in acceptance order.
REQ-011 Push and pop in the same cycle SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 A starve counter SHALL increment each cycle that fifo_count > 0 and no pop occurs, saturate at STARVE_LIMIT, and clear to 0 on a pop or when fifo_count == 0.
REQ-013 pipe_stall SHALL equal (starve counter == STARVE_LIMIT), from registered state only; while high the buffer head SHALL be granted and the pipeline request ignored.
REQ-014 pipe_stall SHALL be high for exactly one cycle per starvation event, since the forced pop clears the counter.
REQ-015 hazard SHALL be 1 when any valid buffer entry's rd equals a nonzero rs1_addr or rs2_addr, including the entry being popped this cycle; it SHALL NOT consider same-cycle lu_rd.

Reset
REQ-016 While rst is high at a rising edge, pointers, fifo_count and the starve counter SHALL clear to 0.
REQ-017 While rst is high, rf_we, lu_ready, pipe_stall and hazard SHALL be 0 regardless of inputs.
REQ-018 Buffer contents present at reset SHALL be discarded and never written; reset mid-stream SHALL take effect on the next edge.

Verification
REQ-019 Accept lu result (rd=5, data=0xDEAD_BEEF) with the pipeline idle -> next cycle rf_we=1, rf_rd=5, rf_data=0xDEAD_BEEF; fifo_count returns to 0.
REQ-020 Continuous pipeline writes (rd=1..) with one buffered entry, STARVE_LIMIT=8 -> pipe_stall=1 on the 9th cycle, buffer entry written that cycle, pipe_stall=0 after.
REQ-021 Push 4 results with the pipeline writing every cycle -> lu_ready=0 at fifo_count=4; a 5th lu_valid is not accepted; ordering holds on drain.
REQ-022 Buffered rd=7, rs1_addr=7 -> hazard=1; rs1_addr=0 with buffered rd=0 attempt -> no entry, hazard=0.
REQ-023 Pipeline request with pipe_rd=0 and one buffered entry -> no pipeline write; buffer head written same cycle.
REQ-024 Assert rst with 3 buffered entries -> fifo_count=0 next cycle, no buffered write ever appears, lu_ready=1 after rst falls.
